// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer among N_REQ byte producers.
// Define UART_TX_ARB_LOCK_EN to let the previous owner hold the bus for multi-byte packets.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_lock_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  input  logic [15:0]        gap_i,
  output logic               tx_en_o,
  output logic [7:0]         tx_byte_o,
  input  logic               tx_done_i,
  output logic               busy_o
);
  localparam int unsigned IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, WAIT_CLR, GAP} state_e;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       byte_q, byte_d;
  logic             busy_q, busy_d;

  logic             rr_found;
  logic [IW-1:0]    rr_idx;
  logic             lock_c;
  logic             win_c;
  logic [IW-1:0]    win_idx;
  logic [7:0]       win_byte;
  logic             arb;

  // First valid requester after last, wrapping modulo N_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_q;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!rr_found && req_valid_i[IW'((32'(last_q) + i) % N_REQ)]) begin
        rr_found = 1'b1;
        rr_idx   = IW'((32'(last_q) + i) % N_REQ);
      end
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  assign lock_c = req_lock_i[last_q];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock_i;
  assign lock_c      = 1'b0;
`endif

  // A held lock restricts the grant to the previous owner.
  always_comb begin
    if (lock_c) begin
      win_c   = req_valid_i[last_q];
      win_idx = last_q;
    end else begin
      win_c   = rr_found;
      win_idx = rr_idx;
    end
  end

  always_comb begin
    win_byte = 8'h00;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_idx == IW'(k)) win_byte = req_data_i[8*k +: 8];
    end
  end

  // Arbitration runs one cycle ahead of the registered ready so the next
  // accept lands 3+gap cycles after done rises.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ready_d = '0;
    grant_d = grant_q;
    tx_en_d = 1'b0;
    byte_d  = byte_q;
    arb     = 1'b0;
    case (state_q)
      IDLE:      arb = 1'b1;
      LAUNCH: begin
        tx_en_d = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: if (tx_done_i) state_d = WAIT_CLR;
      WAIT_CLR: begin
        if (!tx_done_i) begin
          cnt_d = gap_i;
          if (gap_i == 16'd0) arb = 1'b1;
          else                state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q <= 16'd1) begin
          cnt_d = 16'd0;
          arb   = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      if (win_c) begin
        ready_d = ONE << win_idx;
        grant_d = ONE << win_idx;
        byte_d  = win_byte;
        last_d  = win_idx;
        state_d = LAUNCH;
      end else begin
        state_d = IDLE;
        grant_d = lock_c ? (ONE << last_q) : '0;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      last_q  <= IW'(N_REQ - 1);
      ready_q <= '0;
      grant_q <= '0;
      tx_en_q <= 1'b0;
      byte_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      grant_q <= grant_d;
      tx_en_q <= tx_en_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready_o = ready_q;
  assign grant_o     = grant_q;
  assign tx_en_o     = tx_en_q;
  assign tx_byte_o   = byte_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx serializer model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int C = 4;

  logic           clk_i;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_lock_i;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   grant_o;
  logic [15:0]    gap_i;
  logic           tx_en_o;
  logic [7:0]     tx_byte_o;
  logic           tx_done_i;
  logic           busy_o;
  logic           line;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_lock_i(req_lock_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o), .gap_i(gap_i),
    .tx_en_o(tx_en_o), .tx_byte_o(tx_byte_o), .tx_done_i(tx_done_i), .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // uart_tx model: start, 8 data LSB first, stop, then done high for 2 cycles.
  logic       m_busy;
  int         m_j;
  logic [9:0] m_frame;
  always @(posedge clk_i) begin
    if (rst_i) begin
      m_busy  <= 1'b0;
      m_j     <= 0;
      m_frame <= 10'h3FF;
    end else if (!m_busy && tx_en_o) begin
      m_busy  <= 1'b1;
      m_j     <= 0;
      m_frame <= {1'b1, tx_byte_o, 1'b0};
    end else if (m_busy) begin
      if (m_j == 10*C + 1) m_busy <= 1'b0;
      m_j <= m_j + 1;
    end
  end
  assign line      = (m_busy && m_j < 10*C) ? m_frame[4'(m_j / C)] : 1'b1;
  assign tx_done_i = m_busy && (m_j >= 10*C);

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_line[$];
  int         rd_t[$];
  int         dn_t[$];
  logic [7:0] pend[N][$];
  logic [N-1:0] wd_mask;
  int errors = 0;
  int checks = 0;
  int n_rdy  = 0;
  int n_txen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_exp(input int k, input logic [7:0] d, input bit on_line);
    exp_t e;
    e.idx  = 2'(k);
    e.data = d;
    exp_q.push_back(e);
    if (on_line) exp_line.push_back(d);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || exp_line.size() != 0 || busy_o) && t < budget) begin
      @(negedge clk_i);
      t++;
    end
    check(name, 32'(t >= budget), 32'd0);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic wait_count(input string name, input int which, input int n, input int budget);
    int t = 0;
    while (((which == 0) ? rd_t.size() : dn_t.size()) < n && t < budget) begin
      @(negedge clk_i);
      t++;
    end
    check(name, 32'(t >= budget), 32'd0);
  endtask

  // Requester driver: holds valid/data until ready, then presents the next queued byte.
  initial begin
    logic [N-1:0] xfer;
    req_valid_i = '0;
    req_data_i  = '0;
    forever begin
      @(negedge clk_i);
      xfer = req_valid_i & req_ready_o;
      @(posedge clk_i);
      #1;
      for (int k = 0; k < N; k++) begin
        if (wd_mask[k]) begin
          req_valid_i[k] = 1'b0;
          pend[k].delete();
        end else if (!req_valid_i[k] || xfer[k]) begin
          if (pend[k].size() > 0) begin
            req_data_i[8*k +: 8] = pend[k].pop_front();
            req_valid_i[k]       = 1'b1;
          end else begin
            req_valid_i[k] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: ready/grant against the scoreboard, tx_en one cycle after ready with the accepted byte.
  initial begin
    logic       prev_rdy;
    logic       prev_done;
    logic [7:0] cur_byte;
    exp_t       e;
    prev_rdy  = 1'b0;
    prev_done = 1'b0;
    cur_byte  = 8'h00;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (req_ready_o != '0) begin
          n_rdy++;
          rd_t.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 32'(req_ready_o), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ready_onehot", 32'(req_ready_o), 32'(4'b0001 << e.idx));
            check("grant_onehot", 32'(grant_o), 32'(4'b0001 << e.idx));
            cur_byte = e.data;
          end
        end
        if (tx_en_o) n_txen++;
        if (tx_en_o || prev_rdy) begin
          check("tx_en_after_ready", 32'(tx_en_o), 32'(prev_rdy));
          if (tx_en_o) check("tx_byte", 32'(tx_byte_o), 32'(cur_byte));
        end
        if (tx_done_i && !prev_done) dn_t.push_back(cyc);
      end
      prev_rdy  = !rst_i && (req_ready_o != '0);
      prev_done = tx_done_i;
    end
  end

  // Line decoder: mid-bit samples of each frame checked against the expected byte order.
  initial begin
    logic       prev_line;
    logic [9:0] bits;
    logic       abort;
    prev_line = 1'b1;
    forever begin
      @(negedge clk_i);
      if (!rst_i && prev_line && !line) begin
        abort = 1'b0;
        bits  = '0;
        for (int b = 0; b < 10; b++) begin
          repeat ((b == 0) ? C/2 : C) begin
            @(negedge clk_i);
            if (rst_i) abort = 1'b1;
          end
          if (abort) break;
          bits[4'(b)] = line;
        end
        if (!abort) begin
          if (exp_line.size() == 0) check("unexpected_frame", 32'(bits), 32'd0);
          else check("line_frame", 32'(bits), 32'({1'b1, exp_line.pop_front(), 1'b0}));
        end
      end
      prev_line = line;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_i      = 1'b1;
    gap_i      = 16'd0;
    req_lock_i = '0;
    wd_mask    = '0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_tx_en", 32'(tx_en_o), 32'd0);
    check("rst_tx_byte", 32'(tx_byte_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // All four valid, gap 0: A0,A1,A2,A3,A0 at 45-cycle spacing.
    rd_t.delete(); dn_t.delete();
    for (int k = 0; k < N; k++) pend[k].push_back(8'hA0 + 8'(k));
    pend[0].push_back(8'hA0);
    for (int k = 0; k < N; k++) push_exp(k, 8'hA0 + 8'(k), 1'b1);
    push_exp(0, 8'hA0, 1'b1);
    wait_drain("t1_drain", 600);
    check("t1_count", 32'(rd_t.size()), 32'd5);
    for (int i = 1; i < 5; i++) check("t1_period", 32'(rd_t[i] - rd_t[i-1]), 32'd45);

    // Single requester 2 with gap 10: next ready 13 cycles after done rises.
    gap_i = 16'd10;
    rd_t.delete(); dn_t.delete();
    pend[2].push_back(8'h55);
    pend[2].push_back(8'h3C);
    push_exp(2, 8'h55, 1'b1);
    push_exp(2, 8'h3C, 1'b1);
    wait_drain("t2_drain", 400);
    check("t2_count", 32'(rd_t.size()), 32'd2);
    check("t2_gap_latency", 32'(rd_t[1] - dn_t[0]), 32'd13);

    // Requester 1 withdraws just before it would win; requester 3 is served instead.
    gap_i = 16'd20;
    rd_t.delete(); dn_t.delete();
    pend[0].push_back(8'h11);
    push_exp(0, 8'h11, 1'b1);
    wait_count("t3_first_ready", 0, 1, 50);
    pend[1].push_back(8'h99);
    pend[3].push_back(8'h33);
    push_exp(3, 8'h33, 1'b1);
    wait_count("t3_done", 1, 1, 100);
    repeat (20) @(negedge clk_i);
    wd_mask = 4'b0010;
    wait_drain("t3_drain", 300);
    wd_mask = '0;
    check("t3_count", 32'(rd_t.size()), 32'd2);

    // Reset during WAIT_DONE abandons the byte and restores last = N-1.
    gap_i = 16'd0;
    rd_t.delete(); dn_t.delete();
    pend[1].push_back(8'h77);
    push_exp(1, 8'h77, 1'b0);
    wait_count("t4_ready", 0, 1, 50);
    repeat (10) @(negedge clk_i);
    check("t4_busy_before_rst", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("t4_rst_ready", 32'(req_ready_o), 32'd0);
    check("t4_rst_grant", 32'(grant_o), 32'd0);
    check("t4_rst_tx_en", 32'(tx_en_o), 32'd0);
    check("t4_rst_tx_byte", 32'(tx_byte_o), 32'd0);
    check("t4_rst_busy", 32'(busy_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    pend[3].push_back(8'hC3);
    pend[0].push_back(8'h5A);
    push_exp(0, 8'h5A, 1'b1);
    push_exp(3, 8'hC3, 1'b1);
    wait_drain("t4_drain", 300);

    // Requester 1 asserts lock while requester 0 competes.
    req_lock_i = 4'b0010;
`ifdef UART_TX_ARB_LOCK_EN
    pend[0].push_back(8'hB0);
    pend[0].push_back(8'hB1);
    pend[1].push_back(8'hC0);
    pend[1].push_back(8'hC1);
    pend[1].push_back(8'hC2);
    push_exp(0, 8'hB0, 1'b1);
    push_exp(1, 8'hC0, 1'b1);
    push_exp(1, 8'hC1, 1'b1);
    push_exp(1, 8'hC2, 1'b1);
    push_exp(0, 8'hB1, 1'b1);
    begin
      int t = 0;
      while (exp_q.size() > 1 && t < 400) begin
        @(negedge clk_i);
        t++;
      end
      check("t5_lock_wait", 32'(t >= 400), 32'd0);
    end
    req_lock_i = '0;
    wait_drain("t5_drain", 400);
`else
    pend[0].push_back(8'hB0);
    pend[0].push_back(8'hB1);
    pend[1].push_back(8'hC0);
    pend[1].push_back(8'hC1);
    push_exp(0, 8'hB0, 1'b1);
    push_exp(1, 8'hC0, 1'b1);
    push_exp(0, 8'hB1, 1'b1);
    push_exp(1, 8'hC1, 1'b1);
    wait_drain("t5_drain", 400);
`endif
    req_lock_i = '0;

    // gap_i changed from 100 to 2 mid-gap: current gap stays 100, the next uses 2.
    gap_i = 16'd100;
    rd_t.delete(); dn_t.delete();
    pend[2].push_back(8'hD0);
    pend[2].push_back(8'hD1);
    pend[2].push_back(8'hD2);
    push_exp(2, 8'hD0, 1'b1);
    push_exp(2, 8'hD1, 1'b1);
    push_exp(2, 8'hD2, 1'b1);
    wait_count("t6_done", 1, 1, 100);
    repeat (5) @(negedge clk_i);
    gap_i = 16'd2;
    wait_drain("t6_drain", 600);
    check("t6_count", 32'(rd_t.size()), 32'd3);
    check("t6_gap_100", 32'(rd_t[1] - dn_t[0]), 32'd103);
    check("t6_gap_2", 32'(rd_t[2] - dn_t[1]), 32'd5);

    check("tx_en_total", 32'(n_txen), 32'(n_rdy));
    check("scoreboard_empty", 32'(exp_q.size() + exp_line.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
